imem_boot_loader: RTL and testbench

//  Instruction memory with built-in program loader, directly upstream of the pipelined RV32I core's fetch stage.

---
 rtl/imem_boot_loader.sv | 128 ++++++++++++
 tb/tb_imem_boot_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction memory for the RV32I fetch stage with a built-in valid/ready program loader.
// Holds the core in reset until a program is committed and a release delay has elapsed.
module imem_boot_loader #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RELEASE_DLY = 4,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              reload,
  input  logic [31:0]       PCF,
  output logic [31:0]       InstrF,
  output logic              core_reset,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow,
  output logic              misalign
);

  localparam int unsigned DLY_W = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wordCount;
  logic [DLY_W-1:0]  dlyCount;
  logic [31:0]       mem [DEPTH];

  logic              loadFire;
  logic              lastSlot;
  logic [ADDR_W-1:0] fetchIdx;
  logic              fetchHiZero;
  logic              fetchInRange;

  // load_ready is a registered copy of (state == LOAD), so the handshake has no comb loop
  assign loadFire = load_valid & load_ready;
  assign lastSlot = (wordCount == ADDR_W'(DEPTH - 1));

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      wordCount  <= '0;
      dlyCount   <= '0;
      prog_len   <= '0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
      load_ready <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (loadFire) begin
            wordCount <= wordCount + ADDR_W'(1);
            if (load_last || lastSlot) begin
              state      <= HOLD;
              load_ready <= 1'b0;
              dlyCount   <= '0;
              prog_len   <= {1'b0, wordCount} + (ADDR_W + 1)'(1);
              if (lastSlot && !load_last) begin
                overflow <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          dlyCount <= dlyCount + DLY_W'(1);
          if (dlyCount == DLY_W'(RELEASE_DLY - 1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end
        end
        RUN: begin
          if (reload) begin
            state      <= LOAD;
            wordCount  <= '0;
            prog_len   <= '0;
            overflow   <= 1'b0;
            core_reset <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        default: begin
          state      <= LOAD;
          wordCount  <= '0;
          prog_len   <= '0;
          core_reset <= 1'b1;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  // Sticky misaligned-fetch flag, only meaningful once the core is running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (state == RUN && PCF[1:0] != 2'b00) begin
      misalign <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the prog_len gate hides stale words
  always_ff @(posedge clk) begin
    if (loadFire && !reset) begin
      mem[wordCount] <= load_data;
    end
  end

  assign fetchIdx     = PCF[ADDR_W+1:2];
  assign fetchHiZero  = ((PCF >> (ADDR_W + 2)) == 32'd0);
  assign fetchInRange = ({1'b0, fetchIdx} < prog_len);

  always_comb begin
    InstrF = NOP_WORD;
    if (fetchHiZero && fetchInRange) begin
      InstrF = mem[fetchIdx];
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a DEPTH=256 instance for the main flow
// and a DEPTH=4 instance for the overflow / last-slot boundaries.
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  // Instance A: DEPTH 256
  logic        reset, loadValid, loadLast, reload;
  logic [31:0] loadData, pcf;
  logic        loadReady, coreReset, overflow, misalign;
  logic [31:0] instrF;
  logic [8:0]  progLen;

  // Instance B: DEPTH 4
  logic        bReset, bLoadValid, bLoadLast, bReload;
  logic [31:0] bLoadData, bPcf;
  logic        bLoadReady, bCoreReset, bOverflow, bMisalign;
  logic [31:0] bInstrF;
  logic [2:0]  bProgLen;

  imem_boot_loader #(.DEPTH(256), .ADDR_W(8), .RELEASE_DLY(4), .NOP_WORD(NOP)) dutA (
    .clk(clk), .reset(reset), .load_valid(loadValid), .load_ready(loadReady),
    .load_data(loadData), .load_last(loadLast), .reload(reload), .PCF(pcf),
    .InstrF(instrF), .core_reset(coreReset), .prog_len(progLen),
    .overflow(overflow), .misalign(misalign)
  );

  imem_boot_loader #(.DEPTH(4), .ADDR_W(2), .RELEASE_DLY(4), .NOP_WORD(NOP)) dutB (
    .clk(clk), .reset(bReset), .load_valid(bLoadValid), .load_ready(bLoadReady),
    .load_data(bLoadData), .load_last(bLoadLast), .reload(bReload), .PCF(bPcf),
    .InstrF(bInstrF), .core_reset(bCoreReset), .prog_len(bProgLen),
    .overflow(bOverflow), .misalign(bMisalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sendA(input logic [31:0] data, input logic last);
    @(negedge clk);
    loadValid = 1'b1;
    loadData  = data;
    loadLast  = last;
  endtask

  task automatic sendB(input logic [31:0] data, input logic last);
    @(negedge clk);
    bLoadValid = 1'b1;
    bLoadData  = data;
    bLoadLast  = last;
  endtask

  task automatic fetchA(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pcf = addr;
    #1;
    check(tag, instrF, exp);
  endtask

  task automatic fetchB(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bPcf = addr;
    #1;
    check(tag, bInstrF, exp);
  endtask

  initial begin
    reset = 1'b1; loadValid = 1'b0; loadLast = 1'b0; reload = 1'b0;
    loadData = '0; pcf = '0;
    bReset = 1'b1; bLoadValid = 1'b0; bLoadLast = 1'b0; bReload = 1'b0;
    bLoadData = '0; bPcf = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_load_ready", 32'(loadReady), 32'd1);
    check("rst_core_reset", 32'(coreReset), 32'd1);
    check("rst_prog_len",   32'(progLen),   32'd0);
    check("rst_overflow",   32'(overflow),  32'd0);
    check("rst_misalign",   32'(misalign),  32'd0);
    fetchA("rst_instr", 32'h0, NOP);
    reset = 1'b0; bReset = 1'b0;

    // T1: three-word program, release 4 cycles after the last-word edge
    sendA(32'h0050_0093, 1'b0);
    sendA(32'h0010_8113, 1'b0);
    sendA(32'h0000_006F, 1'b1);
    @(negedge clk);
    loadValid = 1'b0; loadLast = 1'b0;
    check("t1_prog_len",   32'(progLen),   32'd3);
    check("t1_overflow",   32'(overflow),  32'd0);
    check("t1_load_ready", 32'(loadReady), 32'd0);
    check("t1_hold_instr", instrF, 32'h0050_0093);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t1_core_reset_hi_%0d", k), 32'(coreReset), 32'd1);
    end
    @(negedge clk);
    check("t1_core_reset_fall", 32'(coreReset), 32'd0);

    // T2: fetch the committed program plus the first unloaded slot
    fetchA("t2_pc0", 32'h0, 32'h0050_0093);
    fetchA("t2_pc4", 32'h4, 32'h0010_8113);
    fetchA("t2_pc8", 32'h8, 32'h0000_006F);
    fetchA("t2_pcC", 32'hC, NOP);
    @(negedge clk);
    check("t2_misalign_clear", 32'(misalign), 32'd0);

    // T6: misaligned PC indexes word 0 and sets the sticky flag; out-of-range PCs give NOP
    fetchA("t6_pc2", 32'h2, 32'h0050_0093);
    @(negedge clk);
    check("t6_misalign", 32'(misalign), 32'd1);
    fetchA("t6_pc400", 32'h400, NOP);
    fetchA("t6_pc3FC", 32'h3FC, NOP);
    pcf = 32'h0;

    // T4: reload a one-word program
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("t4_core_reset",   32'(coreReset), 32'd1);
    check("t4_load_ready",   32'(loadReady), 32'd1);
    check("t4_prog_len",     32'(progLen),   32'd0);
    check("t4_misalign_kept", 32'(misalign), 32'd1);
    fetchA("t4_loading_instr", 32'h0, NOP);
    sendA(32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    loadValid = 1'b0; loadLast = 1'b0;
    check("t4_prog_len_1", 32'(progLen), 32'd1);
    repeat (3) @(negedge clk);
    check("t4_core_reset_hold", 32'(coreReset), 32'd1);
    @(negedge clk);
    check("t4_core_reset_fall", 32'(coreReset), 32'd0);
    fetchA("t4_pc4", 32'h4, NOP);
    fetchA("t4_pc0", 32'h0, 32'hDEAD_BEEF);

    // T5: reset after two of five words, then restream all five
    sendA(32'h1111_1111, 1'b0);
    @(negedge clk);
    check("t5_ignored_in_run", 32'(progLen), 32'd1);
    loadValid = 1'b0;
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    sendA(32'hAAAA_0000, 1'b0);
    sendA(32'hAAAA_0001, 1'b0);
    @(negedge clk);
    loadValid = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_rst_prog_len",   32'(progLen),   32'd0);
    check("t5_rst_load_ready", 32'(loadReady), 32'd1);
    check("t5_rst_core_reset", 32'(coreReset), 32'd1);
    check("t5_rst_misalign",   32'(misalign),  32'd0);
    check("t5_rst_overflow",   32'(overflow),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sendA(32'h5555_0000 + 32'(i), (i == 4));
    end
    @(negedge clk);
    loadValid = 1'b0; loadLast = 1'b0;
    check("t5_prog_len", 32'(progLen), 32'd5);
    repeat (4) @(negedge clk);
    check("t5_core_reset", 32'(coreReset), 32'd0);
    fetchA("t5_pc0",  32'h0,  32'h5555_0000);
    fetchA("t5_pc10", 32'h10, 32'h5555_0004);
    fetchA("t5_pc14", 32'h14, NOP);
    pcf = 32'h0;

    // T3: DEPTH=4, four words without last -> overflow; a fifth word is refused
    for (int i = 0; i < 4; i++) begin
      sendB(32'hA0 + 32'(i), 1'b0);
    end
    @(negedge clk);
    bLoadData = 32'h0000_0BAD;
    check("t3_overflow",   32'(bOverflow),  32'd1);
    check("t3_prog_len",   32'(bProgLen),   32'd4);
    check("t3_load_ready", 32'(bLoadReady), 32'd0);
    repeat (4) @(negedge clk);
    bLoadValid = 1'b0;
    check("t3_core_reset", 32'(bCoreReset), 32'd0);
    check("t3_prog_len_run", 32'(bProgLen), 32'd4);
    fetchB("t3_pc0",  32'h0,  32'hA0);
    fetchB("t3_pcC",  32'hC,  32'hA3);
    fetchB("t3_pc10", 32'h10, NOP);

    // Last word on the final slot: no overflow
    @(negedge clk);
    bReload = 1'b1;
    @(negedge clk);
    bReload = 1'b0;
    check("t3_reload_overflow_clr", 32'(bOverflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sendB(32'hC0 + 32'(i), (i == 3));
    end
    @(negedge clk);
    bLoadValid = 1'b0; bLoadLast = 1'b0;
    check("t3_last_slot_overflow", 32'(bOverflow), 32'd0);
    check("t3_last_slot_prog_len", 32'(bProgLen),  32'd4);
    repeat (4) @(negedge clk);
    fetchB("t3_last_slot_pc8", 32'h8, 32'hC2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
